// File: rtl/joy_db15_responder.sv
// Device-side DB15 joystick responder: parallel-in/serial-out emulation of the adapter shift chain.
// Optional glitch filter on the synchronised joy_clk/joy_load enabled by defining JOY_DB15_RESP_FILTER_EN.
module joy_db15_responder #(
  parameter int unsigned BITS_PER_PLAYER = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FILT_CYCLES     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       joy_clk,
  input  logic                       joy_load,
  input  logic [BITS_PER_PLAYER-1:0] joystick1,
  input  logic [BITS_PER_PLAYER-1:0] joystick2,
  output logic                       joy_data,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [5:0]                 bit_cnt
);

  localparam int unsigned FRAME_BITS = 2 * BITS_PER_PLAYER;
  localparam int unsigned CNT_W      = 6;

  generate
    if (SYNC_STAGES < 2 || BITS_PER_PLAYER > 31 || BITS_PER_PLAYER < 1 || FILT_CYCLES < 1) begin : g_bad_cfg
      $error("joy_db15_responder: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic [1:0]             w_sync;
  logic [1:0]             w_lvl;
  logic [1:0]             r_lvl_prev;

  // Synchronisers preset high so reset never looks like a load or clock edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_clk_sync  <= '1;
      r_load_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], joy_clk};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], joy_load};
    end
  end

  assign w_sync = {r_load_sync[SYNC_STAGES-1], r_clk_sync[SYNC_STAGES-1]};

`ifdef JOY_DB15_RESP_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(FILT_CYCLES + 1);

  logic [1:0]        r_filt;
  logic [FCNT_W-1:0] r_fcnt [2];

  // Level follows the synced input only after FILT_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_filt    <= '1;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCNT_W'(FILT_CYCLES - 1)) begin
          r_filt[i] <= w_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = w_sync;
`endif

  logic w_clk_rise;
  logic w_load_fall;
  logic w_load_rise;

  assign w_clk_rise  = w_lvl[0] & ~r_lvl_prev[0];
  assign w_load_fall = ~w_lvl[1] & r_lvl_prev[1];
  assign w_load_rise = w_lvl[1] & ~r_lvl_prev[1];

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [FRAME_BITS-1:0] w_shreg_nxt;
  logic                  r_data;
  logic                  w_data_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_ovr;
  logic                  w_ovr_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shreg    <= '1;
      r_data     <= 1'b1;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_cnt      <= '0;
      r_lvl_prev <= '1;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_data     <= w_data_nxt;
      r_done     <= w_done_nxt;
      r_ovr      <= w_ovr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lvl_prev <= w_lvl;
    end
  end

  // A load fall from any state restarts the frame; it outranks any coincident clock edge
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;
    w_cnt_nxt   = r_cnt;
    if (w_load_fall) begin
      w_state_nxt = S_LOAD;
      w_shreg_nxt = ~{joystick2, joystick1};
      w_data_nxt  = ~joystick1[0];
      w_cnt_nxt   = '0;
      w_ovr_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_data_nxt = 1'b1;
        end
        S_LOAD: begin
          w_shreg_nxt = ~{joystick2, joystick1};
          w_data_nxt  = ~joystick1[0];
          w_cnt_nxt   = '0;
          if (w_load_rise) begin
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_clk_rise) begin
            w_shreg_nxt = {1'b1, r_shreg[FRAME_BITS-1:1]};
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (w_cnt_nxt == CNT_W'(FRAME_BITS)) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
              w_data_nxt  = 1'b1;
            end else begin
              w_data_nxt  = r_shreg[1];
            end
          end else begin
            w_data_nxt = r_shreg[0];
          end
        end
        S_DONE: begin
          if (w_clk_rise) begin
            w_ovr_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign joy_data   = r_data;
  assign frame_done = r_done;
  assign overrun    = r_ovr;
  assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Self-checking bench for joy_db15_responder: frame-level model plus literal spot checks.
module tb_joy_db15_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        joy_data;
  logic        frame_done;
  logic        overrun;
  logic [5:0]  bit_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;

  // Model: 0 idle, 1 loading, 2 shifting, 3 frame complete
  int          m_mode  = 0;
  int          m_cnt   = 0;
  bit          m_ovr   = 1'b0;
  logic [31:0] m_frame = '0;
  bit          m_valid = 1'b0;

  always #10 clk = ~clk;

  joy_db15_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .overrun    (overrun),
    .bit_cnt    (bit_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
  end

  always @(negedge clk) begin
    logic exp_d;
    if (m_valid) begin
      case (m_mode)
        1:       exp_d = ~joystick1[0];
        2:       exp_d = ~m_frame[m_cnt];
        default: exp_d = 1'b1;
      endcase
      chk("model_joy_data", 32'(joy_data), 32'(exp_d));
      chk("model_bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      chk("model_overrun", 32'(overrun), 32'(m_ovr));
      chk("model_no_stray_done", 32'(frame_done), 32'd0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_load();
    @(posedge clk);
    m_valid  = 1'b0;
    joy_load = 1'b0;
    wait_clk(10);
    m_mode  = 1;
    m_cnt   = 0;
    m_ovr   = 1'b0;
    m_valid = 1'b1;
    wait_clk(5);
    m_valid  = 1'b0;
    m_frame  = {joystick2, joystick1};
    joy_load = 1'b1;
    wait_clk(10);
    m_mode  = 2;
    m_valid = 1'b1;
  endtask

  task automatic jclk_edge();
    @(posedge clk);
    m_valid = 1'b0;
    joy_clk = 1'b1;
    wait_clk(10);
    if (m_mode == 2) begin
      m_cnt++;
      if (m_cnt == 32) m_mode = 3;
    end else if (m_mode == 3) begin
      m_ovr = 1'b1;
    end
    m_valid = 1'b1;
    wait_clk(10);
    joy_clk = 1'b0;
    wait_clk(10);
  endtask

  task automatic jclk_edges(input int n);
    for (int i = 0; i < n; i++) jclk_edge();
  endtask

  initial begin
    logic [31:0] word;
    int          done_snap;

    reset_n   = 1'b0;
    joy_clk   = 1'b0;
    joy_load  = 1'b1;
    joystick1 = '0;
    joystick2 = '0;

    // Reset with joy_clk toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      joy_clk = ~joy_clk;
    end
    @(negedge clk);
    chk("rst_joy_data", 32'(joy_data), 32'd1);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    reset_n = 1'b1;
    joy_clk = 1'b0;
    wait_clk(5);
    m_valid = 1'b1;

    // Clock edges in idle do nothing
    jclk_edges(2);
    chk("idle_overrun", 32'(overrun), 32'd0);

    // Basic frame
    joystick1 = 16'h0005;
    joystick2 = 16'h8000;
    done_snap = n_done;
    do_load();
    word = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      word[i] = ~joy_data;
      jclk_edge();
    end
    chk("frame_word", word, 32'h8000_0005);
    chk("frame_done_count", 32'(n_done - done_snap), 32'd1);
    chk("frame_bit_cnt", 32'(bit_cnt), 32'd32);

    // Aborted frame then full frame
    joystick1 = 16'h1234;
    joystick2 = 16'hA5C3;
    done_snap = n_done;
    do_load();
    jclk_edges(10);
    chk("abort_bit_cnt_10", 32'(bit_cnt), 32'd10);
    do_load();
    chk("reload_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("abort_no_done", 32'(n_done - done_snap), 32'd0);
    jclk_edges(32);
    chk("second_frame_done", 32'(n_done - done_snap), 32'd1);

    // Overrun after complete frame
    jclk_edges(3);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    chk("ovr_joy_data", 32'(joy_data), 32'd1);
    chk("ovr_bit_cnt", 32'(bit_cnt), 32'd32);

    // Joystick change after load rise is not seen
    joystick1 = 16'h0001;
    joystick2 = 16'h0000;
    do_load();
    chk("load_clears_ovr", 32'(overrun), 32'd0);
    joystick1 = 16'h0002;
    word = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      word[i] = ~joy_data;
      jclk_edge();
    end
    chk("frozen_p1", word, 32'h0000_0001);
    jclk_edges(16);
    chk("frozen_bit_cnt", 32'(bit_cnt), 32'd32);

    // Short glitch versus long pulse on joy_clk
    joystick1 = 16'h00FF;
    joystick2 = 16'hFF00;
    do_load();
    @(posedge clk);
    m_valid = 1'b0;
    joy_clk = 1'b1;
    wait_clk(2);
    joy_clk = 1'b0;
    wait_clk(14);
`ifdef JOY_DB15_RESP_FILTER_EN
    chk("glitch_2cyc", 32'(bit_cnt), 32'd0);
`else
    chk("glitch_2cyc", 32'(bit_cnt), 32'd1);
    m_cnt++;
`endif
    m_valid = 1'b1;
    @(posedge clk);
    m_valid = 1'b0;
    joy_clk = 1'b1;
    wait_clk(6);
    joy_clk = 1'b0;
    wait_clk(14);
    m_cnt++;
`ifdef JOY_DB15_RESP_FILTER_EN
    chk("pulse_6cyc", 32'(bit_cnt), 32'd1);
`else
    chk("pulse_6cyc", 32'(bit_cnt), 32'd2);
`endif
    m_valid = 1'b1;

    // Reset mid-frame
    jclk_edges(3);
    @(posedge clk);
    m_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("midrst_joy_data", 32'(joy_data), 32'd1);
    @(posedge clk);
    reset_n = 1'b1;
    m_mode  = 0;
    m_cnt   = 0;
    m_ovr   = 1'b0;
    wait_clk(5);
    m_valid = 1'b1;
    jclk_edge();
    chk("post_rst_idle_cnt", 32'(bit_cnt), 32'd0);
    wait_clk(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
